textmode_ctrl: RTL

TEXTMODE_CTRL -- requirements
Module: textmode_ctrl

---
 rtl/textmode_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/textmode_ctrl.sv
// Text-mode tram controller: clear and scroll commands with a shared, registered
// write port on which CPU writes always win.
module textmode_ctrl #(
  parameter int WORD       = 32,
  parameter int ADDRW      = 14,
  parameter int TRAM_DEPTH = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] text_hres,
  input  logic [ADDRW-1:0] text_vres,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ADDRW-1:0] cmd_lines,
  input  logic [WORD-1:0]  cmd_fill,
  input  logic             cpu_we,
  input  logic [ADDRW-1:0] cpu_addr,
  input  logic [WORD-1:0]  cpu_wdata,
  output logic             tram_we,
  output logic [ADDRW-1:0] tram_waddr,
  output logic [WORD-1:0]  tram_wdata,
  output logic [ADDRW-1:0] scroll_offs,
  output logic             busy
);

  localparam int unsigned      PW    = 2 * ADDRW;
  localparam logic [ADDRW-1:0] LAST  = ADDRW'(TRAM_DEPTH - 1);
  localparam logic [ADDRW:0]   DEPTH = (ADDRW + 1)'(TRAM_DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL_OFFS, SCROLL_FILL} state_t;

  state_t           state;
  logic [ADDRW-1:0] addr;
  logic [ADDRW-1:0] lines_left;
  logic [PW-1:0]    cnt;
  logic [WORD-1:0]  fill;

  logic [ADDRW:0]   offs_sum;
  logic [ADDRW-1:0] offs_next;
  logic [PW-1:0]    row_prod;
  logic [ADDRW-1:0] row_off;
  logic [ADDRW:0]   fill_sum;
  logic [ADDRW-1:0] fill_base;
  logic [ADDRW-1:0] addr_inc;
  logic             issue;

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  // Bottom row start is offs_next + (vres-1)*hres; both terms are already
  // reduced below TRAM_DEPTH, so a single conditional subtract wraps the sum.
  always_comb begin
    offs_sum  = {1'b0, scroll_offs} + {1'b0, text_hres};
    offs_next = (offs_sum >= DEPTH) ? ADDRW'(offs_sum - DEPTH) : offs_sum[ADDRW-1:0];
    row_prod  = PW'(ADDRW'(text_vres - ADDRW'(1))) * PW'(text_hres);
    row_off   = ADDRW'(row_prod % PW'(TRAM_DEPTH));
    fill_sum  = {1'b0, offs_next} + {1'b0, row_off};
    fill_base = (fill_sum >= DEPTH) ? ADDRW'(fill_sum - DEPTH) : fill_sum[ADDRW-1:0];
    addr_inc  = (addr == LAST) ? '0 : addr + 1'b1;
    issue     = ((state == CLEAR) || (state == SCROLL_FILL)) && (cnt != '0) && !cpu_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scroll_offs <= '0;
      addr        <= '0;
      lines_left  <= '0;
      cnt         <= '0;
      fill        <= '0;
      tram_we     <= 1'b0;
      tram_waddr  <= '0;
      tram_wdata  <= '0;
    end else begin
      tram_we    <= cpu_we | issue;
      tram_waddr <= cpu_we ? cpu_addr : addr;
      tram_wdata <= cpu_we ? cpu_wdata : fill;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            fill       <= cmd_fill;
            lines_left <= cmd_lines;
            case (cmd_op)
              2'd0: begin
                state <= CLEAR;
                addr  <= scroll_offs;
                cnt   <= PW'(text_hres) * PW'(text_vres);
              end
              2'd1: if (cmd_lines != '0) state <= SCROLL_OFFS;
              2'd2: scroll_offs <= '0;
              default: ;
            endcase
          end
        end
        CLEAR: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else if (issue) begin
            addr <= addr_inc;
            cnt  <= cnt - 1'b1;
            if (cnt == PW'(1)) state <= IDLE;
          end
        end
        SCROLL_OFFS: begin
          scroll_offs <= offs_next;
          addr        <= fill_base;
          cnt         <= PW'(text_hres);
          state       <= SCROLL_FILL;
        end
        SCROLL_FILL: begin
          if (issue) begin
            addr <= addr_inc;
            cnt  <= cnt - 1'b1;
          end
          if ((cnt == '0) || (issue && (cnt == PW'(1)))) begin
            if (lines_left == ADDRW'(1)) begin
              state <= IDLE;
            end else begin
              lines_left <= lines_left - 1'b1;
              state      <= SCROLL_OFFS;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
